uart_frame_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: parity modes, FSM encoding
// and the rounded baud divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } uart_state_e;

    // Nearest-integer clocks per bit, e.g. 1 MHz / 300 kbit/s -> 3.
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..DIV-1 and flags the last cycle of each bit period.
module uart_bit_timer #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign bit_end_o = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart_i || bit_end_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: captures NBYTES bytes on a start strobe and sends
// them MSB byte first, each character LSB first, with optional parity and gaps.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int NBYTES    = 6,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [8*NBYTES-1:0]   tx_data,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  trans_done,
    output uart_state_e           state_o
);

    localparam int          BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
    localparam int          W         = 8 * NBYTES;
    localparam logic [4:0]  LAST_BYTE = 5'(NBYTES - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]  GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    uart_state_e  state_q;
    logic [W-1:0] shreg_q;
    logic [4:0]   byte_idx_q;
    logic [3:0]   per_q;
    logic         tx_q;
    logic         busy_q;
    logic         done_q;

    logic [7:0]   cur_byte;
    logic         par_bit;
    logic         bit_end;
    logic         restart;

    assign cur_byte = shreg_q[W-1 -: 8];
    assign par_bit  = (PARITY == PAR_ODD) ? ~^cur_byte : ^cur_byte;
    // Holding the timer cleared while idle makes every state start on a fresh period.
    assign restart  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    uart_bit_timer #(
        .DIV(BAUD_DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .bit_end_o (bit_end)
    );

    // Handshake: tx_start is accepted only in IDLE or DONE (busy low); otherwise dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            per_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (tx_start) begin
                        state_q    <= ST_START;
                        shreg_q    <= tx_data;
                        byte_idx_q <= '0;
                        per_q      <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        per_q   <= '0;
                        tx_q    <= cur_byte[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (per_q == 4'd7) begin
                            per_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            per_q <= per_q + 4'd1;
                            tx_q  <= cur_byte[per_q[2:0] + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        per_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (per_q == STOP_LAST) begin
                            per_q <= '0;
                            if (byte_idx_q == LAST_BYTE) begin
                                state_q <= ST_DONE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                byte_idx_q <= byte_idx_q + 5'd1;
                                shreg_q    <= shreg_q << 8;
                                if (GAP_BITS > 0) begin
                                    state_q <= ST_GAP;
                                    tx_q    <= 1'b1;
                                end else begin
                                    state_q <= ST_START;
                                    tx_q    <= 1'b0;
                                end
                            end
                        end else begin
                            per_q <= per_q + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (bit_end) begin
                        if (per_q == GAP_LAST) begin
                            state_q <= ST_START;
                            per_q   <= '0;
                            tx_q    <= 1'b0;
                        end else begin
                            per_q <= per_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign trans_done = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: five parameterisations checked bit by bit
// against a bench-built line model, plus back-to-back and mid-transfer reset.
module tb_uart_frame_tx;
    import uart_pkg::*;

    typedef struct {
        int          inst;
        logic [47:0] data;
        int          nbytes;
        int          parity;
        int          stop;
        int          gap;
        int          div;
        int          exp_len;
        int          exp_par;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  start = '0;
    logic [47:0] data_drv [5];
    wire  [4:0]  line_w;
    wire  [4:0]  busy_w;
    wire  [4:0]  done_w;
    uart_state_e st_w [5];

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];
    vec_t vecs [7];

    always #5 clk = ~clk;

    uart_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NBYTES(2), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0))
    u_a (.clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data_drv[0][15:0]),
         .uart_tx(line_w[0]), .busy(busy_w[0]), .trans_done(done_w[0]), .state_o(st_w[0]));
    uart_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NBYTES(1), .PARITY(2), .STOP_BITS(2), .GAP_BITS(0))
    u_b (.clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data_drv[1][7:0]),
         .uart_tx(line_w[1]), .busy(busy_w[1]), .trans_done(done_w[1]), .state_o(st_w[1]));
    uart_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .NBYTES(1), .PARITY(1), .STOP_BITS(2), .GAP_BITS(0))
    u_c (.clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data_drv[2][7:0]),
         .uart_tx(line_w[2]), .busy(busy_w[2]), .trans_done(done_w[2]), .state_o(st_w[2]));
    uart_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .GAP_BITS(3))
    u_d (.clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data_drv[3]),
         .uart_tx(line_w[3]), .busy(busy_w[3]), .trans_done(done_w[3]), .state_o(st_w[3]));
    uart_frame_tx #(.CLK_FREQ(1_000_000), .BAUD(300_000), .NBYTES(1))
    u_e (.clk(clk), .rst(rst), .tx_start(start[4]), .tx_data(data_drv[4][7:0]),
         .uart_tx(line_w[4]), .busy(busy_w[4]), .trans_done(done_w[4]), .state_o(st_w[4]));

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_start(input int inst, input logic [47:0] data);
        @(negedge clk);
        data_drv[inst] = data;
        start[inst]    = 1'b1;
        @(posedge clk);
        #1 start[inst] = 1'b0;
    endtask

    // Called right after the accepting edge; returns at the trans_done cycle.
    task automatic check_stream(input vec_t v);
        logic [0:0] got[$];
        logic [7:0] byte_v;
        logic [7:0] dec;
        int c_len, busy_cnt, bad_cyc, pos;
        bit early_done;
        exp_q.delete();
        c_len = 10 + ((v.parity != 0) ? 1 : 0) + (v.stop - 1);
        for (int b = 0; b < v.nbytes; b++) begin
            byte_v = v.data[8*(v.nbytes-1-b) +: 8];
            exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(byte_v[i]);
            if (v.parity == 1) exp_q.push_back(~^byte_v);
            if (v.parity == 2) exp_q.push_back(^byte_v);
            for (int i = 0; i < v.stop; i++) exp_q.push_back(1'b1);
            if (b < v.nbytes - 1)
                for (int i = 0; i < v.gap; i++) exp_q.push_back(1'b1);
        end
        busy_cnt   = 0;
        early_done = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            bad_cyc = -1;
            for (int c = 0; c < v.div; c++) begin
                @(negedge clk);
                if (line_w[v.inst] !== exp_q[k][0] && bad_cyc < 0) bad_cyc = c;
                if (busy_w[v.inst] === 1'b1) busy_cnt++;
                if (done_w[v.inst] !== 1'b0) early_done = 1'b1;
                if (c == v.div / 2) got.push_back(line_w[v.inst]);
            end
            check(bad_cyc < 0, $sformatf("bit inst=%0d k=%0d cyc=%0d", v.inst, k, bad_cyc),
                  int'(got[k][0]), int'(exp_q[k][0]));
        end
        for (int b = 0; b < v.nbytes; b++) begin
            pos = b * (c_len + v.gap);
            for (int i = 0; i < 8; i++) dec[i] = got[pos + 1 + i][0];
            byte_v = v.data[8*(v.nbytes-1-b) +: 8];
            check(dec == byte_v, $sformatf("byte inst=%0d b=%0d", v.inst, b), int'(dec), int'(byte_v));
        end
        if (v.exp_par >= 0)
            check(int'(got[9][0]) == v.exp_par, $sformatf("parity inst=%0d", v.inst),
                  int'(got[9][0]), v.exp_par);
        check(busy_cnt == v.exp_len, $sformatf("busy_len inst=%0d", v.inst), busy_cnt, v.exp_len);
        @(negedge clk);
        check(!early_done && done_w[v.inst] === 1'b1 && busy_w[v.inst] === 1'b0 && line_w[v.inst] === 1'b1,
              $sformatf("done_cycle inst=%0d early=%0d", v.inst, early_done),
              int'({done_w[v.inst], busy_w[v.inst], line_w[v.inst]}), 3'b101);
    endtask

    task automatic check_idle(input int inst, input int cycles, input string name);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_w[inst] !== 1'b0 || busy_w[inst] !== 1'b0 || line_w[inst] !== 1'b1) bad++;
        end
        check(bad == 0, name, bad, 0);
    endtask

    initial begin
        vec_t v1, v2;
        for (int i = 0; i < 5; i++) data_drv[i] = '0;
        vecs[0] = '{0, 48'hA55A,         2, 0, 1, 0, 10, 200, -1};
        vecs[1] = '{1, 48'h07,           1, 2, 2, 0, 10, 120,  1};
        vecs[2] = '{2, 48'h07,           1, 1, 2, 0, 10, 120,  0};
        vecs[3] = '{3, 48'h0123456789AB, 6, 0, 1, 3, 10, 750, -1};
        vecs[4] = '{4, 48'h96,           1, 0, 1, 0,  3,  30, -1};
        vecs[5] = '{1, 48'hF0,           1, 2, 2, 0, 10, 120,  0};
        vecs[6] = '{2, 48'h00,           1, 1, 2, 0, 10, 120,  1};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++)
            check(line_w[i] === 1'b1 && busy_w[i] === 1'b0 && done_w[i] === 1'b0 && st_w[i] == ST_IDLE,
                  $sformatf("reset inst=%0d", i),
                  int'({line_w[i], busy_w[i], done_w[i]}), 3'b100);
        rst = 1'b0;
        check_idle(0, 5, "idle_after_reset");

        for (int n = 0; n < 7; n++) begin
            drive_start(vecs[n].inst, vecs[n].data);
            check_stream(vecs[n]);
            check_idle(vecs[n].inst, 3, $sformatf("post_done vec=%0d", n));
        end

        v1 = '{0, 48'h1234, 2, 0, 1, 0, 10, 200, -1};
        v2 = '{0, 48'hBEEF, 2, 0, 1, 0, 10, 200, -1};
        @(negedge clk);
        data_drv[0] = 48'h1234;
        start[0]    = 1'b1;
        @(posedge clk);
        #1 data_drv[0] = 48'hBEEF;
        check_stream(v1);
        fork
            check_stream(v2);
            begin
                repeat (100) @(negedge clk);
                start[0] = 1'b0;
            end
        join
        check_idle(0, 40, "no_extra_transfer");

        drive_start(0, 48'hC3C3);
        repeat (45) @(negedge clk);
        check(line_w[0] === 1'b0, "pre_reset_d3", int'(line_w[0]), 0);
        #2 rst = 1'b1;
        #1 check(line_w[0] === 1'b1 && busy_w[0] === 1'b0 && done_w[0] === 1'b0 && st_w[0] == ST_IDLE,
                 "reset_async", int'({line_w[0], busy_w[0], done_w[0]}), 3'b100);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle(0, 40, "idle_after_abort");
        v1.data = 48'h3CA5;
        drive_start(0, v1.data);
        check_stream(v1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
